// File: rtl/video_pipe_delay.sv
// Fixed-latency video pipe with input-side frame measurement, lock detection and blanking.
// Defining VIDEO_PIPE_PATTERN_EN adds pattern_en and an output-side colour-bar generator.

module video_pipe_delay #(
    parameter int DATA_W         = 24,
    parameter int DELAY          = 2,
    parameter bit BLANK_UNLOCKED = 1'b1,
    parameter int TMO_W          = 22
) (
    input  logic              PixelClk,
    input  logic              pRst,
    input  logic [DATA_W-1:0] vid_pData,
    input  logic              vid_pVDE,
    input  logic              vid_pHSync,
    input  logic              vid_pVSync,
`ifdef VIDEO_PIPE_PATTERN_EN
    input  logic              pattern_en,
`endif
    output logic [DATA_W-1:0] out_pData,
    output logic              out_pVDE,
    output logic              out_pHSync,
    output logic              out_pVSync,
    output logic [11:0]       active_width,
    output logic [11:0]       active_height,
    output logic              frame_locked,
    output logic [15:0]       frame_cnt
);

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              vde;
        logic              hs;
        logic              vs;
    } pix_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    pix_t pipe_q [DELAY];
    pix_t pipe_d [DELAY];

    logic             vde_prev_q, vde_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic [11:0]      pix_cnt_q, pix_cnt_d;
    logic [11:0]      line_cnt_q, line_cnt_d;
    logic [11:0]      line_len_q, line_len_d;
    logic [11:0]      act_w_q, act_w_d;
    logic [11:0]      act_h_q, act_h_d;
    logic             armed_q, armed_d;
    logic             locked_q, locked_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             vde_fall, vs_rise;
    logic [11:0]      lines_now, len_now;

    always_comb begin
        pipe_d[0] = '{data: vid_pData, vde: vid_pVDE, hs: vid_pHSync, vs: vid_pVSync};
        for (int i = 1; i < DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        vde_fall    = vde_prev_q & ~vid_pVDE;
        vs_rise     = vid_pVSync & ~vs_prev_q;
        vde_prev_d  = vid_pVDE;
        vs_prev_d   = vid_pVSync;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        line_len_d  = line_len_q;
        act_w_d     = act_w_q;
        act_h_d     = act_h_q;
        armed_d     = armed_q;
        locked_d    = locked_q;
        frame_cnt_d = frame_cnt_q;
        tmo_d       = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

        // The line is closed before the frame, so a coincident VSync edge sees the final line.
        if (vde_fall) begin
            line_len_d = pix_cnt_q;
            pix_cnt_d  = '0;
            line_cnt_d = sat_inc12(line_cnt_q);
        end else if (vid_pVDE) begin
            pix_cnt_d = sat_inc12(pix_cnt_q);
        end
        lines_now = line_cnt_d;
        len_now   = line_len_d;

        if (vs_rise) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            tmo_d       = '0;
            line_cnt_d  = '0;
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if (lines_now != 12'd0) begin
                act_h_d  = lines_now;
                act_w_d  = len_now;
                locked_d = (lines_now == act_h_q) && (len_now == act_w_q) && (len_now != 12'd0);
            end
        end

        // Losing VSync for the full timeout window drops lock and forces a fresh arming frame.
        if (tmo_d == TMO_MAX) begin
            locked_d = 1'b0;
            armed_d  = 1'b0;
        end
    end

    always_ff @(posedge PixelClk) begin
        if (pRst) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
            vde_prev_q  <= 1'b0;
            vs_prev_q   <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            line_len_q  <= '0;
            act_w_q     <= '0;
            act_h_q     <= '0;
            armed_q     <= 1'b0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
            tmo_q       <= '0;
        end else begin
            pipe_q      <= pipe_d;
            vde_prev_q  <= vde_prev_d;
            vs_prev_q   <= vs_prev_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line_len_q  <= line_len_d;
            act_w_q     <= act_w_d;
            act_h_q     <= act_h_d;
            armed_q     <= armed_d;
            locked_q    <= locked_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

`ifdef VIDEO_PIPE_PATTERN_EN
    localparam int CW = DATA_W / 3;

    logic [11:0] x_q, x_d;

    // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
    function automatic logic [DATA_W-1:0] bar_color(input logic [2:0] idx);
        return {{CW{~idx[1]}}, {CW{~idx[2]}}, {CW{~idx[0]}}};
    endfunction

    always_comb begin
        x_d = pipe_q[DELAY-1].vde ? sat_inc12(x_q) : 12'd0;
    end

    always_ff @(posedge PixelClk) begin
        if (pRst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end
`endif

    always_comb begin
        out_pVDE   = pipe_q[DELAY-1].vde;
        out_pHSync = pipe_q[DELAY-1].hs;
        out_pVSync = pipe_q[DELAY-1].vs;
        out_pData  = pipe_q[DELAY-1].data;
        if (BLANK_UNLOCKED && !locked_q) begin
            out_pData = '0;
        end
`ifdef VIDEO_PIPE_PATTERN_EN
        if (pattern_en && pipe_q[DELAY-1].vde) begin
            out_pData = bar_color(x_q[9:7]);
        end
`endif
    end

    assign active_width  = act_w_q;
    assign active_height = act_h_q;
    assign frame_locked  = locked_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_video_pipe_delay.sv
// Bench for video_pipe_delay: five instances (DELAY 2/1/16, blanking, short timeout)
// share one stimulus; pipeline checked against a sample history, frames against a vector table.

module tb_video_pipe_delay;

    localparam int DW = 24;
    localparam int N  = 5;
    localparam int DLYS [N] = '{2, 1, 16, 2, 2};
    localparam bit BLK  [N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam int TMOS [N] = '{22, 22, 22, 22, 9};
    localparam int FR = 3;
    localparam int TM = 4;
    localparam int HB = 4;
    localparam logic [23:0] BAR [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic [DW-1:0] d;
        logic          vde;
        logic          hs;
        logic          vs;
    } smp_t;

    typedef struct {
        int w;
        int h;
        bit tight;
        int ew;
        int eh;
        bit el;
        int efc;
    } fvec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] d   = '0;
    logic          vde = 1'b0;
    logic          hs  = 1'b0;
    logic          vs  = 1'b0;
`ifdef VIDEO_PIPE_PATTERN_EN
    logic          pat_en = 1'b0;
`endif

    logic [DW-1:0] od [N];
    logic          ov [N];
    logic          oh [N];
    logic          os [N];
    logic [11:0]   aw [N];
    logic [11:0]   ah [N];
    logic          lk [N];
    logic [15:0]   fc [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        video_pipe_delay #(
            .DATA_W(DW), .DELAY(DLYS[g]), .BLANK_UNLOCKED(BLK[g]), .TMO_W(TMOS[g])
        ) u_dut (
            .PixelClk(clk), .pRst(rst),
            .vid_pData(d), .vid_pVDE(vde), .vid_pHSync(hs), .vid_pVSync(vs),
`ifdef VIDEO_PIPE_PATTERN_EN
            .pattern_en((g == FR) ? pat_en : 1'b0),
`endif
            .out_pData(od[g]), .out_pVDE(ov[g]), .out_pHSync(oh[g]), .out_pVSync(os[g]),
            .active_width(aw[g]), .active_height(ah[g]),
            .frame_locked(lk[g]), .frame_cnt(fc[g])
        );
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc_n   = 0;
    int    last_bnd = 0;
    int    orun = 0;
    int    xidx = 0;
    bit    cur_lock = 1'b0;
    bit    chk_fr = 1'b0;
    bit    pat_active = 1'b0;
    smp_t  hist [16];
    fvec_t fv [13];

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom());
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic check_outputs();
        smp_t        e;
        logic [23:0] exp_d;
        for (int i = 0; i < N; i++) begin
            e = hist[DLYS[i]-1];
            chk($sformatf("sync_u%0d", i), 32'({ov[i], oh[i], os[i]}), 32'({e.vde, e.hs, e.vs}));
            if (i < FR) begin
                chk($sformatf("data_u%0d", i), 32'(od[i]), 32'(e.d));
            end else if (i == FR && chk_fr) begin
                if (pat_active && e.vde) exp_d = BAR[(xidx >> 7) & 7];
                else if (cur_lock)       exp_d = e.d;
                else                     exp_d = '0;
                chk("data_blank_u3", 32'(od[i]), 32'(exp_d));
            end
        end
    endtask

    task automatic step(input logic [DW-1:0] di, input logic v, input logic h, input logic s);
        d = di; vde = v; hs = h; vs = s;
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst) begin
            for (int k = 0; k < 16; k++) hist[k] = '0;
            orun = 0;
        end else begin
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = '{d: di, vde: v, hs: h, vs: s};
        end
        if (hist[1].vde) begin
            xidx = orun;
            orun++;
        end else begin
            orun = 0;
        end
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur_lock = 1'b0;
        step(rnd(), 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_width_u%0d", i),  32'(aw[i]), 32'd0);
            chk($sformatf("rst_height_u%0d", i), 32'(ah[i]), 32'd0);
            chk($sformatf("rst_fcnt_u%0d", i),   32'(fc[i]), 32'd0);
            chk($sformatf("rst_lock_u%0d", i),   32'(lk[i]), 32'd0);
        end
    endtask

    task automatic run_frame(input int idx);
        fvec_t r;
        r = fv[idx];
        cur_lock = r.el;
        for (int c = 0; c < r.w + HB; c++) begin
            step(rnd(), 1'b0, c < 2, 1'b1);
            if (c == 0) begin
                last_bnd = cyc_n;
                chk($sformatf("f%0d_width", idx),  32'(aw[FR]), 32'(r.ew));
                chk($sformatf("f%0d_height", idx), 32'(ah[FR]), 32'(r.eh));
                chk($sformatf("f%0d_lock", idx),   32'(lk[FR]), 32'(r.el));
                chk($sformatf("f%0d_fcnt", idx),   32'(fc[FR]), 32'(r.efc));
            end
        end
        for (int c = 0; c < r.w + HB; c++) step(rnd(), 1'b0, c < 2, 1'b0);
        for (int ln = 0; ln < r.h; ln++) begin
            for (int c = 0; c < r.w; c++) step(rnd(), 1'b1, 1'b0, 1'b0);
            if (!(r.tight && ln == r.h - 1)) begin
                for (int c = 0; c < HB; c++) step(rnd(), 1'b0, c < 2, 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        //        w   h  tight ew  eh  lock fcnt
        fv[0]  = '{16, 6, 1'b0,  0,  0, 1'b0,  1};
        fv[1]  = '{16, 6, 1'b0, 16,  6, 1'b0,  2};
        fv[2]  = '{16, 6, 1'b0, 16,  6, 1'b1,  3};
        fv[3]  = '{16, 6, 1'b0, 16,  6, 1'b1,  4};
        fv[4]  = '{12, 4, 1'b0, 16,  6, 1'b1,  5};
        fv[5]  = '{16, 6, 1'b0, 12,  4, 1'b0,  6};
        fv[6]  = '{16, 6, 1'b1, 16,  6, 1'b0,  7};
        fv[7]  = '{16, 6, 1'b0, 16,  6, 1'b1,  8};
        fv[8]  = '{16, 6, 1'b1, 16,  6, 1'b1,  9};
        fv[9]  = '{10, 3, 1'b0, 16,  6, 1'b1, 10};
        fv[10] = '{16, 6, 1'b0,  0,  0, 1'b0,  1};
        fv[11] = '{16, 6, 1'b0, 16,  6, 1'b0,  2};
        fv[12] = '{16, 6, 1'b0, 16,  6, 1'b1,  3};
        for (int i = 0; i < 16; i++) hist[i] = '0;

        do_reset();

        // Ramp data from 1 with assorted sync patterns, then fully random samples.
        for (int i = 0; i < 48; i++) begin
            step(DW'(i + 1), i[0], i[2], i[3]);
        end
        for (int i = 0; i < 300; i++) begin
            step(rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        do_reset();
        chk_fr = 1'b1;
        for (int i = 0; i < 10; i++) run_frame(i);

        // Boundary closing the 10x3 frame, then reset in the middle of the third active line.
        cur_lock = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(rnd(), 1'b0, c < 2, 1'b1);
            if (c == 0) begin
                chk("pre_rst_lock", 32'(lk[FR]), 32'd0);
                chk("pre_rst_width", 32'(aw[FR]), 32'd10);
                chk("pre_rst_height", 32'(ah[FR]), 32'd3);
                chk("pre_rst_fcnt", 32'(fc[FR]), 32'd11);
            end
        end
        for (int c = 0; c < 20; c++) step(rnd(), 1'b0, c < 2, 1'b0);
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 0; c < 16; c++) step(rnd(), 1'b1, 1'b0, 1'b0);
            for (int c = 0; c < HB; c++) step(rnd(), 1'b0, c < 2, 1'b0);
        end
        for (int c = 0; c < 8; c++) step(rnd(), 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 8; c++) step(rnd(), 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < HB; c++) step(rnd(), 1'b0, c < 2, 1'b0);
        for (int i = 10; i < 13; i++) run_frame(i);

        // VSync stops: the short-timeout instance must drop lock 2^9-1 clocks after the last boundary.
        chk("tmo_locked_before", 32'(lk[TM]), 32'd1);
        k = 0;
        while (lk[TM] === 1'b1 && k < 2000) begin
            step(rnd(), 1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("tmo_drop_cycles", 32'(cyc_n - last_bnd), 32'd511);
        chk("tmo_fcnt", 32'(fc[TM]), 32'd3);
        chk("long_tmo_still_locked", 32'(lk[FR]), 32'd1);

`ifdef VIDEO_PIPE_PATTERN_EN
        do_reset();
        pat_en = 1'b1;
        pat_active = 1'b1;
        for (int c = 0; c < 1100; c++) step(rnd(), 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step(rnd(), 1'b0, 1'b0, 1'b0);
        pat_en = 1'b0;
        pat_active = 1'b0;
        for (int c = 0; c < 4; c++) step(rnd(), 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
